// File: rtl/snake_pkg.sv
// Shared snake-game constants, coordinate widths, food placer states and the
// on-grid legality test used by food placement and snake spawn.
package snake_pkg;

    localparam int X_W       = 10;
    localparam int Y_W       = 9;
    localparam int CELL      = 10;
    localparam int X_MAX     = 630;
    localparam int Y_MAX     = 470;
    localparam int INIT_X    = 200;
    localparam int INIT_Y    = 200;
    localparam int MAX_TRIES = 15;
    localparam int TRY_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CHECK,
        ST_WAIT,
        ST_PUBLISH
    } state_t;

    // On-screen and cell-aligned; compared at full port width, no truncation.
    function automatic logic coord_legal(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x <= X_W'(X_MAX)) && (y <= Y_W'(Y_MAX)) &&
               ((x % X_W'(CELL)) == '0) && ((y % Y_W'(CELL)) == '0);
    endfunction

endpackage

// File: rtl/food_candidate_check.sv
// Combinational candidate filter: bounds, cell alignment and head collision.
// Zero latency, no flow control; result is valid in the same cycle as inputs.
module food_candidate_check
    import snake_pkg::*;
(
    input  logic [X_W-1:0] cand_x,
    input  logic [Y_W-1:0] cand_y,
    input  logic [X_W-1:0] head_x,
    input  logic [Y_W-1:0] head_y,
    output logic           cand_ok
);

    logic on_head;

    assign on_head = (cand_x == head_x) && (cand_y == head_y);
    assign cand_ok = coord_legal(cand_x, cand_y) && !on_head;

endmodule

// File: rtl/food_placer.sv
// Retires eaten food and places a new legal, unoccupied food cell.
// Eat to new food_valid is 4 cycles best case; rejected samples retry forever.
module food_placer
    import snake_pkg::*;
(
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic [X_W-1:0] rand_x,
    input  logic [Y_W-1:0] rand_y,
    input  logic [X_W-1:0] head_x,
    input  logic [Y_W-1:0] head_y,
    input  logic           head_valid,
    output logic           query_req,
    output logic [X_W-1:0] query_x,
    output logic [Y_W-1:0] query_y,
    input  logic           query_hit,
    output logic [X_W-1:0] food_x,
    output logic [Y_W-1:0] food_y,
    output logic           food_valid,
    output logic           eaten,
    output logic           place_fail,
    output logic           busy
);

    state_t           state_q, state_d;
    logic [X_W-1:0]   cand_x_q, cand_x_d;
    logic [Y_W-1:0]   cand_y_q, cand_y_d;
    logic [X_W-1:0]   food_x_q, food_x_d;
    logic [Y_W-1:0]   food_y_q, food_y_d;
    logic             food_valid_q, food_valid_d;
    logic             eaten_q, eaten_d;
    logic             place_fail_q, place_fail_d;
    logic             query_req_q, query_req_d;
    logic [X_W-1:0]   query_x_q, query_x_d;
    logic [Y_W-1:0]   query_y_q, query_y_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             busy_q, busy_d;
    logic             cand_ok;
    logic             head_on_food;
    logic             reject;

    food_candidate_check u_check (
        .cand_x  (cand_x_q),
        .cand_y  (cand_y_q),
        .head_x  (head_x),
        .head_y  (head_y),
        .cand_ok (cand_ok)
    );

    assign head_on_food = head_valid && food_valid_q &&
                          (head_x == food_x_q) && (head_y == food_y_q);

    always_comb begin
        state_d      = state_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        eaten_d      = 1'b0;
        place_fail_d = 1'b0;
        query_req_d  = 1'b0;
        query_x_d    = query_x_q;
        query_y_d    = query_y_q;
        tries_d      = tries_q;
        reject       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (head_on_food) begin
                    eaten_d      = 1'b1;
                    food_valid_d = 1'b0;
                    state_d      = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                cand_x_d = rand_x;
                cand_y_d = rand_y;
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                if (cand_ok) begin
                    query_req_d = 1'b1;
                    query_x_d   = cand_x_q;
                    query_y_d   = cand_y_q;
                    state_d     = ST_WAIT;
                end else begin
                    reject = 1'b1;
                end
            end
            ST_WAIT: begin
                if (query_hit) begin
                    reject = 1'b1;
                end else begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                food_x_d     = cand_x_q;
                food_y_d     = cand_y_q;
                food_valid_d = 1'b1;
                tries_d      = '0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A failure pulse is only a warning; the search keeps sampling.
        if (reject) begin
            state_d = ST_SAMPLE;
            if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                place_fail_d = 1'b1;
                tries_d      = '0;
            end else begin
                tries_d = tries_q + 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            food_x_q     <= X_W'(INIT_X);
            food_y_q     <= Y_W'(INIT_Y);
            food_valid_q <= 1'b1;
            eaten_q      <= 1'b0;
            place_fail_q <= 1'b0;
            query_req_q  <= 1'b0;
            query_x_q    <= '0;
            query_y_q    <= '0;
            tries_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            eaten_q      <= eaten_d;
            place_fail_q <= place_fail_d;
            query_req_q  <= query_req_d;
            query_x_q    <= query_x_d;
            query_y_q    <= query_y_d;
            tries_q      <= tries_d;
            busy_q       <= busy_d;
        end
    end

    assign query_req  = query_req_q;
    assign query_x    = query_x_q;
    assign query_y    = query_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign eaten      = eaten_q;
    assign place_fail = place_fail_q;
    assign busy       = busy_q;

endmodule
